// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled deserialiser for NB_DATA-bit, 1-start/SB_TICK-stop frames.
// Presents each good byte with a one-cycle done strobe and flags a low stop bit as a framing error.
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic [1:0]         o_dbg_state
);

    // s_cnt must reach both 15 (data bits) and SB_TICK-1 (stop), so never narrower than 4 bits.
    localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int N_W = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(7);
    localparam logic [S_W-1:0] S_LAST = S_W'(15);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Handshake: o_rx_done and o_frame_err are mutually exclusive single-cycle strobes; o_data
    // is valid in the o_rx_done cycle and holds until the next good frame. There is no ready.

    logic               rx_meta_q;
    logic               rx_s_q;
    state_t             state_q, state_d;
    logic [S_W-1:0]     s_cnt_q, s_cnt_d;
    logic [N_W-1:0]     n_cnt_q, n_cnt_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               rx_done_q, rx_done_d;
    logic               frame_err_q, frame_err_d;

    // Both synchroniser flops reset to the idle-high line level so reset never fakes a start edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            s_cnt_q     <= '0;
            n_cnt_q     <= '0;
            b_q         <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            n_cnt_q     <= n_cnt_d;
            b_q         <= b_d;
            data_q      <= data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        n_cnt_d     = n_cnt_q;
        b_d         = b_q;
        data_d      = data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Leaving IDLE does not wait for a tick; edge detection is at full clock rate.
                if (!rx_s_q) begin
                    state_d = ST_START;
                    s_cnt_d = '0;
                end
            end

            ST_START: begin
                if (i_tick) begin
                    if (s_cnt_q == S_MID) begin
                        if (!rx_s_q) begin
                            state_d = ST_DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (i_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        b_d     = {rx_s_q, b_q[NB_DATA-1:1]};
                        if (n_cnt_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (i_tick) begin
                    if (s_cnt_q == S_STOP) begin
                        state_d = ST_IDLE;
                        if (rx_s_q) begin
                            data_d    = b_q;
                            rx_done_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign o_data      = data_q;
    assign o_rx_done   = rx_done_q;
    assign o_frame_err = frame_err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16-tick and 32-tick stop instances, good/glitch/error/break/reset frames.
module tb_uart_rx;

  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       rx1, rx2;
  int         tick_cnt = 0;

  logic [7:0] data1, data2;
  logic       done1, done2, ferr1, ferr2;
  logic [1:0] st1, st2;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         done1_cnt = 0, ferr1_cnt = 0;
  int         done2_cnt = 0, ferr2_cnt = 0;
  bit         finished = 1'b0;

  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (tick_cnt == 9) tick_cnt <= 0;
    else               tick_cnt <= tick_cnt + 1;
  end
  assign tick = (tick_cnt == 9);

  uart_rx u_dut16 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_tick      (tick),
    .i_rx        (rx1),
    .o_data      (data1),
    .o_rx_done   (done1),
    .o_frame_err (ferr1),
    .o_dbg_state (st1)
  );

  uart_rx #(.NB_DATA(8), .SB_TICK(32)) u_dut32 (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_tick      (tick),
    .i_rx        (rx2),
    .o_data      (data2),
    .o_rx_done   (done2),
    .o_frame_err (ferr2),
    .o_dbg_state (st2)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (done1 || ferr1) check_eq("rx16_strobe_excl", done1 & ferr1, 0);
    if (done2 || ferr2) check_eq("rx32_strobe_excl", done2 & ferr2, 0);
    if (done1) begin
      done1_cnt++;
      check_eq("rx16_done_expected", exp_q1.size() > 0, 1);
      if (exp_q1.size() > 0) check_eq("rx16_data", data1, exp_q1.pop_front());
    end
    if (done2) begin
      done2_cnt++;
      check_eq("rx32_done_expected", exp_q2.size() > 0, 1);
      if (exp_q2.size() > 0) check_eq("rx32_data", data2, exp_q2.pop_front());
    end
    if (ferr1) ferr1_cnt++;
    if (ferr2) ferr2_cnt++;
  end

  // ---------------- drivers ----------------
  task automatic set_line(input int which, input logic v);
    if (which == 2) rx2 = v;
    else            rx1 = v;
  endtask

  // Called on a falling edge; returns on the falling edge `clocks` cycles later.
  task automatic hold(input int which, input logic v, input int clocks);
    set_line(which, v);
    repeat (clocks) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input logic stop_v,
                            input int stop_clks);
    hold(which, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(which, b[i], BIT_CLKS);
    hold(which, stop_v, stop_clks);
    set_line(which, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    check_eq("timeout_finished", finished, 1);
    report();
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d0, e0, d2;
    logic [7:0] b81;
    b81 = 8'h81;
    rst = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    check_eq("reset_data",  data1, 8'h00);
    check_eq("reset_done",  done1, 0);
    check_eq("reset_ferr",  ferr1, 0);
    check_eq("reset_state", st1, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    hold(1, 1'b1, 200);

    // good frame 0xA5
    d0 = done1_cnt; e0 = ferr1_cnt;
    exp_q1.push_back(8'hA5);
    send_frame(1, 8'hA5, 1'b1, BIT_CLKS);
    hold(1, 1'b1, 100);
    #2;
    check_eq("a5_done_count", done1_cnt - d0, 1);
    check_eq("a5_ferr_count", ferr1_cnt - e0, 0);
    check_eq("a5_data_held",  data1, 8'hA5);
    @(negedge clk);

    // start glitch: 4 ticks low, rejected at mid start bit
    d0 = done1_cnt; e0 = ferr1_cnt;
    hold(1, 1'b0, 40);
    hold(1, 1'b1, 300);
    #2;
    check_eq("glitch_done_count", done1_cnt - d0, 0);
    check_eq("glitch_ferr_count", ferr1_cnt - e0, 0);
    check_eq("glitch_data",       data1, 8'hA5);
    check_eq("glitch_state_idle", st1, 2'd0);
    @(negedge clk);

    // 0x3C with a low stop bit; line released before the re-armed start reaches mid-bit
    d0 = done1_cnt; e0 = ferr1_cnt;
    send_frame(1, 8'h3C, 1'b0, 100);
    hold(1, 1'b1, 300);
    #2;
    check_eq("ferr_ferr_count", ferr1_cnt - e0, 1);
    check_eq("ferr_done_count", done1_cnt - d0, 0);
    check_eq("ferr_data_kept",  data1, 8'hA5);
    @(negedge clk);

    // back-to-back frames, no idle gap
    d0 = done1_cnt; e0 = ferr1_cnt;
    exp_q1.push_back(8'h00);
    exp_q1.push_back(8'hFF);
    exp_q1.push_back(8'h55);
    send_frame(1, 8'h00, 1'b1, BIT_CLKS);
    send_frame(1, 8'hFF, 1'b1, BIT_CLKS);
    send_frame(1, 8'h55, 1'b1, BIT_CLKS);
    hold(1, 1'b1, 100);
    #2;
    check_eq("b2b_done_count", done1_cnt - d0, 3);
    check_eq("b2b_ferr_count", ferr1_cnt - e0, 0);
    check_eq("b2b_last_data",  data1, 8'h55);
    check_eq("b2b_queue_empty", exp_q1.size(), 0);
    @(negedge clk);

    // reset in the middle of bit 4 of 0x81; transmitter abandons the frame
    d0 = done1_cnt; e0 = ferr1_cnt;
    hold(1, 1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold(1, b81[i], BIT_CLKS);
    hold(1, b81[4], 80);
    rst = 1'b1;
    rx1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_eq("midrst_data",  data1, 8'h00);
    check_eq("midrst_state", st1, 2'd0);
    @(negedge clk);
    hold(1, 1'b1, 400);
    #2;
    check_eq("midrst_no_done", done1_cnt - d0, 0);
    check_eq("midrst_no_ferr", ferr1_cnt - e0, 0);
    check_eq("midrst_data_idle", data1, 8'h00);
    @(negedge clk);
    exp_q1.push_back(8'h81);
    send_frame(1, 8'h81, 1'b1, BIT_CLKS);
    hold(1, 1'b1, 100);
    #2;
    check_eq("clean81_done_count", done1_cnt - d0, 1);
    check_eq("clean81_data",       data1, 8'h81);
    @(negedge clk);

    // continuous break: two framing errors of data 0x00, released before a third start is accepted
    d0 = done1_cnt; e0 = ferr1_cnt;
    hold(1, 1'b0, 3070);
    hold(1, 1'b1, 600);
    #2;
    check_eq("break_ferr_count", ferr1_cnt - e0, 2);
    check_eq("break_done_count", done1_cnt - d0, 0);
    check_eq("break_data_kept",  data1, 8'h81);
    @(negedge clk);

    // SB_TICK=32 instance, 0x7E with two stop bits: no done at the one-stop-bit point
    d2 = done2_cnt;
    exp_q2.push_back(8'h7E);
    send_frame(2, 8'h7E, 1'b1, BIT_CLKS);
    #2;
    check_eq("sb32_no_early_done", done2_cnt - d2, 0);
    @(negedge clk);
    hold(2, 1'b1, 200);
    #2;
    check_eq("sb32_done_count", done2_cnt - d2, 1);
    check_eq("sb32_data",       data2, 8'h7E);
    check_eq("sb32_ferr_count", ferr2_cnt, 0);
    check_eq("sb16_line_idle_no_extra", done1_cnt - d0, 0);
    check_eq("final_queue1_empty", exp_q1.size(), 0);
    check_eq("final_queue2_empty", exp_q2.size(), 0);

    finished = 1'b1;
    report();
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, directly downstream of the baud-rate tick generator. Consumes its 16x-oversampling tick (one pulse per 1/16 bit period) and deserialises 8N1 frames (configurable data bits and stop ticks) from the asynchronous serial line. Presents each received byte with a one-cycle done strobe to the ALU interface logic, plus a framing-error strobe.

Parameters:
NB_DATA, 8, number of data bits per frame, LSB first
SB_TICK, 16, oversampling ticks spent in stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_tick  in  1  oversampling tick from baud generator, 1-cycle pulse, 16 per bit period
i_rx  in  1  asynchronous serial input, idle high
o_data  out  NB_DATA  last received byte, held until next successful frame
o_rx_done  out  1  1-cycle strobe, o_data valid and updated
o_frame_err  out  1  1-cycle strobe, stop bit sampled low

Behaviour:
- Clock i_clock; reset i_reset, synchronous, active-high.
- Input sync: i_rx through 2-flop synchroniser, both flops reset to 1; FSM sees only the synchronised rx_s. Adds 2 cycles of input latency.
- Counters: s_cnt 4 bits wide minimum, sized for SB_TICK-1 (tick count within bit). n_cnt $clog2(NB_DATA) bits (data-bit index). Shift reg b_reg NB_DATA bits. All counters advance only on cycles with i_tick=1.
- FSM states, reset to IDLE:
  - IDLE: rx_s==0 (start edge) -> START, s_cnt=0. i_tick not required to leave IDLE.
  - START: on tick, s_cnt==7 (mid start bit): rx_s==0 -> DATA, s_cnt=0, n_cnt=0. rx_s==1 -> IDLE (glitch rejected, no strobes). Otherwise s_cnt++.
  - DATA: on tick, s_cnt==15 -> s_cnt=0, b_reg={rx_s, b_reg[NB_DATA-1:1]} (LSB first). If n_cnt==NB_DATA-1 -> STOP, else n_cnt++. Otherwise s_cnt++.
  - STOP: on tick, s_cnt==SB_TICK-1 -> IDLE. rx_s==1: o_data<=b_reg, o_rx_done=1 next cycle. rx_s==0: o_frame_err=1 next cycle, o_data unchanged. Otherwise s_cnt++.
- Outputs registered. o_rx_done and o_frame_err never high together and each high exactly one i_clock cycle per frame.
- Reset values: o_data=0, o_rx_done=0, o_frame_err=0, b_reg=0, s_cnt=0, n_cnt=0, state=IDLE.
- Reset mid-frame: returns to IDLE next cycle; partial frame discarded, no strobe.
- Line held low after framing error: IDLE sees rx_s==0 and restarts START immediately. START rejects it only if line rises by mid-bit; a continuous break yields repeated framing errors of data 0x00, no done strobes.
- Back-to-back frames: next start edge accepted in the cycle after leaving STOP; no idle gap required.
- i_tick asserted with no frame in progress has no effect.
- Sampling tolerance: bits sampled at tick 8 of 16 relative to detected start edge; ±1 tick jitter on edge detection tolerated.

Test Plan:
- Bench drives i_tick every 10 clocks; frame 0xA5 (line 0, 1,0,1,0,0,1,0,1, 1, 160 clocks per bit) -> single o_rx_done pulse, o_data=8'hA5, o_frame_err=0.
- Start glitch: i_rx low for 4 ticks (40 clocks) then high -> FSM returns to IDLE, no strobes, o_data keeps previous value.
- Frame 0x3C with stop bit driven 0 -> o_frame_err 1-cycle pulse, o_rx_done stays 0, o_data unchanged from prior 0xA5.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three o_rx_done pulses, o_data sequence 00, FF, 55.
- i_reset asserted for 1 cycle during bit 4 of frame 0x81, then a clean 0x81 frame -> outputs 0 after reset, no strobe for aborted frame, then one done with o_data=8'h81.
- SB_TICK=32 instance, frame 0x7E with 2 stop bits -> done strobe after 32 stop ticks, o_data=8'h7E.
